nfifo_rr_sched: RTL and testbench
=================================

NFIFO_RR_SCHED -- requirements
Module: nfifo_rr_sched

Interface
REQ-001 SHALL have parameter FLOWS, default 4, the number of flow buffers scheduled (2..16).
REQ-002 SHALL have parameter BLOCK_SIZE, default 16, the maximum words read from one flow per grant (1..256).
REQ-003 SHALL have port CLK  in  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port ENABLE  in  1  allows new grants when high.
REQ-006 SHALL have port FLOW_EMPTY  in  FLOWS  per-flow buffer empty flag.
REQ-007 SHALL have port DST_RDY  in  1  downstream can accept a word this cycle.
REQ-008 SHALL have port RD  out  FLOWS  one-hot read strobe to the flow buffers.
REQ-009 SHALL have port SEL  out  log2(FLOWS)  index of the granted flow, for the output mux.
REQ-010 SHALL have port ACTIVE  out  1  high while in state BURST.

Function
REQ-011 SHALL implement FSM states IDLE and BURST.
REQ-012 In IDLE with ENABLE=1 and any FLOW_EMPTY bit low, SHALL pick the first non-empty flow searching cyclically from PTR+1 and enter BURST next cycle with SEL=picked index and burst counter=0.
REQ-013 In IDLE, RD SHALL be all-zero (one-cycle arbitration bubble per grant).
REQ-014 In BURST, RD[SEL] SHALL be high combinationally exactly when DST_RDY=1 and FLOW_EMPTY[SEL]=0; all other RD bits low.
REQ-015 Each cycle with RD[SEL]=1 SHALL increment the burst counter.
REQ-016 SHALL return to IDLE the cycle after the read that brings the counter to BLOCK_SIZE.
REQ-017 SHALL return to IDLE the cycle after FLOW_EMPTY[SEL]=1 is sampled in BURST with no read, so an emptied flow releases its grant.
REQ-018 On leaving BURST, SHALL set PTR:=SEL, so the released flow has lowest priority next.
REQ-019 DST_RDY=0 in BURST SHALL hold state, counter and SEL unchanged, with no timeout.
REQ-020 ENABLE=0 SHALL not abort a running burst; it only blocks IDLE->BURST.
REQ-021 Burst counter width SHALL be log2(BLOCK_SIZE)+1 and SHALL not wrap.
REQ-022 The PTR search SHALL wrap from FLOWS-1 to 0.

Reset
REQ-023 RESET low SHALL immediately force IDLE, PTR=FLOWS-1 (first search starts at flow 0), counter=0, SEL=0, RD=0, ACTIVE=0.
REQ-024 Reset mid-burst SHALL drop RD asynchronously; no partial-burst state survives.

Configuration
REQ-025 With macro NFIFO_SCHED_STATS_EN defined, SHALL add output STAT_WORDS (FLOWS*32): per-flow 32-bit counters of RD pulses, saturating at 0xFFFFFFFF, cleared only by RESET.
REQ-026 Without NFIFO_SCHED_STATS_EN, the STAT_WORDS port and its counters SHALL not exist; all other behaviour identical.

Structure
REQ-027 The FSM state enum, the log2 helper function and the default-parameter constants SHALL live in shared package nfifo_sched_pkg.
REQ-028 The cyclic first-one search SHALL be sub-module nfifo_rr_pick (inputs: request vector, pointer; outputs: index, found), purely combinational.

Verification
REQ-029 Reset release; flows 0..3 each hold 40 words; DST_RDY=1 -> bursts of 16 words in order 0,1,2,3,0,... with a 1-cycle RD gap between bursts.
REQ-030 Only flow 2 non-empty, holding 5 words -> 5 RD[2] pulses, then IDLE; PTR=2.
REQ-031 Flow 1 in BURST; DST_RDY toggles 1,0,1,0 -> RD only on DST_RDY=1 cycles; counter reaches 16 after 16 accepted reads.
REQ-032 ENABLE dropped at the 3rd read of a burst -> burst completes all 16 words, then no new grant until ENABLE=1.
REQ-033 RESET asserted at the 7th read of flow 3 -> RD=0 in the same cycle; after release, the first grant goes to the lowest-index non-empty flow (flow 0 if non-empty).
REQ-034 With NFIFO_SCHED_STATS_EN: 100 words read from flow 0 -> STAT_WORDS[31:0]=100 and the other counters=0.

Source files
------------

// File: rtl/nfifo_sched_pkg.sv
// Shared types, constants and helpers for the round-robin flow-buffer scheduler.
package nfifo_sched_pkg;

  localparam int DEF_FLOWS      = 4;
  localparam int DEF_BLOCK_SIZE = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } sched_state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int log2_ceil(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nfifo_rr_pick.sv
// Combinational cyclic first-one search: first set request strictly after ptr_i,
// wrapping from FLOWS-1 to 0 (ptr_i itself is examined last).
module nfifo_rr_pick
  import nfifo_sched_pkg::*;
#(
  parameter int FLOWS = DEF_FLOWS,
  parameter int PW    = log2_ceil(DEF_FLOWS)
) (
  input  logic [FLOWS-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [PW-1:0]    idx_o,
  output logic             found_o
);

  int          cand;
  logic [PW-1:0] cand_idx;

  // Walk candidates farthest-first so the nearest hit overwrites earlier ones.
  always_comb begin
    idx_o    = '0;
    found_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = FLOWS; i >= 1; i--) begin
      cand     = (int'(ptr_i) + i) % FLOWS;
      cand_idx = cand[PW-1:0];
      if (req_i[cand_idx]) begin
        idx_o   = cand_idx;
        found_o = 1'b1;
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/nfifo_rr_sched.sv
// Round-robin burst scheduler over FLOWS flow buffers, up to BLOCK_SIZE words per grant.
// Optional per-flow read counters on STAT_WORDS when NFIFO_SCHED_STATS_EN is defined.
module nfifo_rr_sched
  import nfifo_sched_pkg::*;
#(
  parameter int FLOWS      = DEF_FLOWS,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        ENABLE,
  input  logic [FLOWS-1:0]            FLOW_EMPTY,
  input  logic                        DST_RDY,
  output logic [FLOWS-1:0]            RD,
  output logic [log2_ceil(FLOWS)-1:0] SEL,
  output logic                        ACTIVE
`ifdef NFIFO_SCHED_STATS_EN
  ,
  output logic [FLOWS*32-1:0]         STAT_WORDS
`endif
);

  localparam int PW = log2_ceil(FLOWS);
  localparam int CW = log2_ceil(BLOCK_SIZE) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_SIZE);

  sched_state_e  state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc_s;
  logic [PW-1:0] pick_idx_s;
  logic          pick_found_s;
  logic          rd_fire_s;
  logic          sel_empty_s;

  nfifo_rr_pick #(
    .FLOWS (FLOWS),
    .PW    (PW)
  ) u_pick (
    .req_i   (~FLOW_EMPTY),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx_s),
    .found_o (pick_found_s)
  );

  assign sel_empty_s = FLOW_EMPTY[sel_q];
  assign rd_fire_s   = (state_q == ST_BURST) && DST_RDY && !sel_empty_s;
  assign cnt_inc_s   = cnt_q + {{(CW-1){1'b0}}, 1'b1};

  // Read strobe is combinational so the buffer pops in the same cycle the word is accepted.
  always_comb begin
    RD = '0;
    if (rd_fire_s) begin
      RD[sel_q] = 1'b1;
    end else begin
      RD = '0;
    end
  end

  // Next-state: grant in IDLE, count/release in BURST; a stalled burst simply holds.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ENABLE && pick_found_s) begin
          state_d = ST_BURST;
          sel_d   = pick_idx_s;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (rd_fire_s) begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == CNT_LAST) begin
            state_d = ST_IDLE;
            ptr_d   = sel_q;
            cnt_d   = '0;
          end else begin
            state_d = ST_BURST;
          end
        end else if (sel_empty_s) begin
          state_d = ST_IDLE;
          ptr_d   = sel_q;
          cnt_d   = '0;
        end else begin
          state_d = ST_BURST;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset points the search just before flow 0.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(FLOWS - 1);
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign SEL    = sel_q;
  assign ACTIVE = (state_q == ST_BURST);

`ifdef NFIFO_SCHED_STATS_EN
  logic [31:0] stat_q [FLOWS];

  // Saturating per-flow read counters, cleared only by reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int f = 0; f < FLOWS; f++) begin
        stat_q[f] <= 32'd0;
      end
    end else begin
      for (int f = 0; f < FLOWS; f++) begin
        if (RD[f] && (stat_q[f] != 32'hFFFF_FFFF)) begin
          stat_q[f] <= stat_q[f] + 32'd1;
        end else begin
          stat_q[f] <= stat_q[f];
        end
      end
    end
  end

  // Flatten counters onto the output bus, flow 0 in the low word.
  always_comb begin
    STAT_WORDS = '0;
    for (int f = 0; f < FLOWS; f++) begin
      STAT_WORDS[f*32 +: 32] = stat_q[f];
    end
  end
`endif

endmodule

// File: tb/tb_nfifo_rr_sched.sv
// Self-checking bench for nfifo_rr_sched: directed scenarios plus random traffic,
// compared cycle by cycle against a word-count reference model of the scheduler.
module tb_nfifo_rr_sched;

  localparam int F  = 4;
  localparam int BS = 16;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         ENABLE = 1'b0;
  logic [F-1:0] FLOW_EMPTY = '1;
  logic         DST_RDY = 1'b0;
  logic [F-1:0] RD;
  logic [1:0]   SEL;
  logic         ACTIVE;
`ifdef NFIFO_SCHED_STATS_EN
  logic [F*32-1:0] STAT_WORDS;
`endif

  nfifo_rr_sched #(.FLOWS(F), .BLOCK_SIZE(BS)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .FLOW_EMPTY (FLOW_EMPTY),
    .DST_RDY    (DST_RDY),
    .RD         (RD),
    .SEL        (SEL),
    .ACTIVE     (ACTIVE)
`ifdef NFIFO_SCHED_STATS_EN
    ,
    .STAT_WORDS (STAT_WORDS)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: words held per flow, current grant (or none), rotation pointer.
  int        words [F];
  bit        m_busy;
  int        m_sel;
  int        m_ptr;
  int        m_cnt;
  logic [F-1:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_ptr  = F - 1;
    m_cnt  = 0;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    model_reset();
    #1;
    check("reset_rd", 32'(RD), 32'd0);
    check("reset_sel", 32'(SEL), 32'd0);
    check("reset_active", 32'(ACTIVE), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input bit en, input bit dst);
    logic [F-1:0] exp_rd;
    bit fire;
    bit sel_empty;
    ENABLE  = en;
    DST_RDY = dst;
    for (int f = 0; f < F; f++) FLOW_EMPTY[f] = (words[f] == 0);
    #1;
    exp_rd = '0;
    fire   = 1'b0;
    if (m_busy && dst && words[m_sel] > 0) begin
      fire = 1'b1;
      exp_rd[m_sel] = 1'b1;
    end
    last_rd = RD;
    check("rd", 32'(RD), 32'(exp_rd));
    check("sel", 32'(SEL), 32'(m_sel));
    check("active", 32'(ACTIVE), 32'(m_busy));
    sel_empty = (words[m_sel] == 0);
    @(posedge CLK);
    if (m_busy) begin
      if (fire) begin
        words[m_sel]--;
        m_cnt++;
        if (m_cnt == BS) begin
          m_busy = 1'b0;
          m_ptr  = m_sel;
        end
      end else if (sel_empty) begin
        m_busy = 1'b0;
        m_ptr  = m_sel;
      end
    end else if (en) begin
      for (int j = 1; j <= F; j++) begin
        if (!m_busy && words[(m_ptr + j) % F] > 0) begin
          m_busy = 1'b1;
          m_sel  = (m_ptr + j) % F;
          m_cnt  = 0;
        end
      end
    end
    #1;
  endtask

  initial begin
    int pulses;
    int reads;
    bit en;
    bit dst;
    bit hit;
    for (int f = 0; f < F; f++) words[f] = 0;
    model_reset();
    last_rd = '0;
    @(posedge CLK);
    #1;
    do_reset();

    // Four full flows, downstream always ready: 16-word bursts in flow order.
    for (int f = 0; f < F; f++) words[f] = 40;
    for (int c = 0; c < 160; c++) step(1'b1, 1'b1);

    // Only flow 2, five words; then the released pointer makes flow 3 beat flow 1.
    do_reset();
    for (int f = 0; f < F; f++) words[f] = 0;
    words[2] = 5;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 1'b1);
      if (last_rd[2]) pulses++;
    end
    check("flow2_pulses", 32'(pulses), 32'd5);
    check("flow2_idle", 32'(ACTIVE), 32'd0);
    words[1] = 3;
    words[3] = 3;
    step(1'b1, 1'b1);
    check("ptr_after_flow2", 32'(SEL), 32'd3);
    for (int c = 0; c < 12; c++) step(1'b1, 1'b1);

    // Flow 1 with downstream toggling: only accepted cycles count toward 16.
    do_reset();
    for (int f = 0; f < F; f++) words[f] = 0;
    words[1] = 40;
    pulses = 0;
    dst = 1'b1;
    for (int c = 0; c < 80 && pulses < 16; c++) begin
      step(1'b1, dst);
      if (last_rd[1]) pulses++;
      dst = ~dst;
    end
    check("toggle_pulses", 32'(pulses), 32'd16);
    check("toggle_release", 32'(ACTIVE), 32'd0);

    // ENABLE dropped at the third read: burst still completes, then no grant.
    do_reset();
    for (int f = 0; f < F; f++) words[f] = 40;
    reads = 0;
    en = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step(en, 1'b1);
      if (last_rd != '0) reads++;
      if (reads == 2) en = 1'b0;
    end
    check("enable_burst_len", 32'(reads), 32'd16);
    check("enable_hold_idle", 32'(ACTIVE), 32'd0);
    for (int c = 0; c < 20; c++) step(1'b1, 1'b1);

    // Reset on the 7th read of flow 3, then flow 0 wins the first grant.
    do_reset();
    for (int f = 0; f < F; f++) words[f] = 0;
    words[3] = 40;
    reads = 0;
    for (int c = 0; c < 200 && reads < 6; c++) begin
      step(1'b1, 1'b1);
      if (last_rd[3]) reads++;
    end
    check("flow3_six_reads", 32'(reads), 32'd6);
    ENABLE  = 1'b1;
    DST_RDY = 1'b1;
    for (int f = 0; f < F; f++) FLOW_EMPTY[f] = (words[f] == 0);
    #1;
    check("seventh_read_live", 32'(RD), 32'b1000);
    RESET = 1'b0;
    #1;
    check("async_rd_drop", 32'(RD), 32'd0);
    check("async_active_drop", 32'(ACTIVE), 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    words[0] = 10;
    step(1'b1, 1'b1);
    check("post_reset_grant", 32'(SEL), 32'd0);
    for (int c = 0; c < 30; c++) step(1'b1, 1'b1);

    // Random traffic, stalls, enable gaps and refills.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int f = 0; f < F; f++) begin
        if ($urandom_range(0, 15) == 0) words[f] += $urandom_range(1, 20);
      end
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0));
    end

`ifdef NFIFO_SCHED_STATS_EN
    // Per-flow read counters after 100 words from flow 0.
    do_reset();
    for (int f = 0; f < F; f++) words[f] = 0;
    words[0] = 100;
    for (int c = 0; c < 200; c++) step(1'b1, 1'b1);
    check("stat_flow0", STAT_WORDS[31:0], 32'd100);
    check("stat_flow1", STAT_WORDS[63:32], 32'd0);
    check("stat_flow2", STAT_WORDS[95:64], 32'd0);
    check("stat_flow3", STAT_WORDS[127:96], 32'd0);
`endif

    hit = (n_fail == 0);
    if (!hit) $display("FAIL summary: %0d comparisons failed", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
